// File: rtl/mult_rr_arbiter.sv
// Round-robin front end that lets N requesters share one sequential multiplier.
// Each transaction runs IDLE -> RUN -> DONE, so mul_start always drops between jobs.
module mult_rr_arbiter #(
    parameter int N       = 4,
    parameter int WIDTH   = 4,
    parameter int MUL_LAT = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           req,
    input  logic [N*WIDTH-1:0]     a_in,
    input  logic [N*WIDTH-1:0]     b_in,
    output logic [N-1:0]           done,
    output logic [2*WIDTH-1:0]     res_out,
    output logic [$clog2(N)-1:0]   res_id,
    output logic                   busy,
    output logic                   mul_start,
    output logic [WIDTH-1:0]       mul_a,
    output logic [WIDTH-1:0]       mul_b,
    input  logic [2*WIDTH-1:0]     mul_o
);

    localparam int IDW   = $clog2(N);
    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N-1:0]       done_q, done_d;
    logic [2*WIDTH-1:0] res_q, res_d;
    logic [IDW-1:0]     id_q, id_d;
    logic               busy_q, busy_d;
    logic               start_q, start_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;

    logic               grant_vld;
    logic [IDW-1:0]     grant_idx;
    logic [IDW-1:0]     grant_nxt;
    logic [IDW-1:0]     scan_idx;
    int                 scan_pos;
    int                 nxt_pos;

    // Scan from ptr downward in priority order; the last hit (closest to ptr) wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        scan_pos  = 0;
        for (int k = N - 1; k >= 0; k--) begin
            scan_pos = int'(ptr_q) + k;
            if (scan_pos >= N) scan_pos = scan_pos - N;
            scan_idx = IDW'(scan_pos);
            if (req[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end
        nxt_pos = int'(grant_idx) + 1;
        if (nxt_pos >= N) nxt_pos = 0;
        grant_nxt = IDW'(nxt_pos);
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        res_d   = res_q;
        id_d    = id_q;
        busy_d  = busy_q;
        start_d = start_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    a_d     = a_in[grant_idx*WIDTH +: WIDTH];
                    b_d     = b_in[grant_idx*WIDTH +: WIDTH];
                    id_d    = grant_idx;
                    ptr_d   = grant_nxt;
                    cnt_d   = '0;
                    start_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_q == CNT_LAST) begin
                    res_d        = mul_o;
                    done_d       = '0;
                    done_d[id_q] = 1'b1;
                    start_d      = 1'b0;
                    state_d      = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                done_d  = '0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                done_d  = '0;
                busy_d  = 1'b0;
                start_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            done_q  <= '0;
            res_q   <= '0;
            id_q    <= '0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            res_q   <= res_d;
            id_q    <= id_d;
            busy_q  <= busy_d;
            start_q <= start_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign done      = done_q;
    assign res_out   = res_q;
    assign res_id    = id_q;
    assign busy      = busy_q;
    assign mul_start = start_q;
    assign mul_a     = a_q;
    assign mul_b     = b_q;

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// Directed bench for mult_rr_arbiter: a small 4-bit instance and a 32-bit instance,
// each driving a behavioural multiplier whose output is only correct after MUL_LAT start cycles.
module tb_mult_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  req;
    logic [15:0] a_in, b_in;
    logic [3:0]  done;
    logic [7:0]  res_out;
    logic [1:0]  res_id;
    logic        busy, mul_start;
    logic [3:0]  mul_a, mul_b;
    logic [7:0]  mul_o;

    mult_rr_arbiter #(.N(4), .WIDTH(4), .MUL_LAT(6)) dut (
        .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
        .done(done), .res_out(res_out), .res_id(res_id), .busy(busy),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_o(mul_o)
    );

    logic [3:0]   req_w;
    logic [127:0] a_w, b_w;
    logic [3:0]   done_w;
    logic [63:0]  res_w;
    logic [1:0]   id_w;
    logic         busy_w, start_w;
    logic [31:0]  ma_w, mb_w;
    logic [63:0]  mo_w;

    mult_rr_arbiter #(.N(4), .WIDTH(32), .MUL_LAT(34)) dut_w (
        .clk(clk), .rst(rst), .req(req_w), .a_in(a_w), .b_in(b_w),
        .done(done_w), .res_out(res_w), .res_id(id_w), .busy(busy_w),
        .mul_start(start_w), .mul_a(ma_w), .mul_b(mb_w), .mul_o(mo_w)
    );

    // Multiplier models: product valid only once start has been seen high MUL_LAT-1 edges.
    int         mcnt, mcnt_w;
    logic [7:0]  prod;
    logic [63:0] prod_w;
    assign prod   = {4'b0, mul_a} * {4'b0, mul_b};
    assign prod_w = {32'b0, ma_w} * {32'b0, mb_w};
    assign mul_o  = (mcnt == 5) ? prod : ~prod;
    assign mo_w   = (mcnt_w == 33) ? prod_w : ~prod_w;
    always @(posedge clk) begin
        mcnt   <= mul_start ? mcnt + 1 : 0;
        mcnt_w <= start_w ? mcnt_w + 1 : 0;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int got_id, got_cyc, got_st;
    logic [7:0] got_res;

    task automatic do_reset();
        rst = 1'b1; req = '0; req_w = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits (bounded) for a done pulse, drops the served req; id=-1 on timeout, -2 if not one-hot.
    task automatic wait_done(output int id, output logic [7:0] res, output int cyc, output int st);
        id = -1; res = '0; cyc = -1; st = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (mul_start) st++;
            if (done != 4'b0) begin
                cyc = i; res = res_out; id = -2;
                for (int j = 0; j < 4; j++) if (done == (4'b1 << j)) id = j;
                if (id >= 0) req[id] = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; req_w = '0;
        a_in = 16'hFFFF; b_in = 16'hFFFF; a_w = '0; b_w = '0;
        repeat (3) @(negedge clk);
        n_tests++; if (done !== 4'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0000", done); end
        n_tests++; if (busy !== 1'b0 || mul_start !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl busy=%b start=%b exp=0/0", busy, mul_start); end
        n_tests++; if (res_out !== 8'd0 || res_id !== 2'd0) begin n_fail++; $display("FAIL reset_res res=%0d id=%0d exp=0/0", res_out, res_id); end
        n_tests++; if (mul_a !== 4'd0 || mul_b !== 4'd0) begin n_fail++; $display("FAIL reset_ops a=%0d b=%0d exp=0/0", mul_a, mul_b); end
        rst = 1'b0; req = '0;
    endtask

    task automatic test_single();
        do_reset();
        a_in = 16'h0020; b_in = 16'h0030; req = 4'b0010;
        wait_done(got_id, got_res, got_cyc, got_st);
        n_tests++; if (got_id !== 1 || res_id !== 2'd1) begin n_fail++; $display("FAIL single_id got=%0d res_id=%0d exp=1", got_id, res_id); end
        n_tests++; if (got_res !== 8'd6) begin n_fail++; $display("FAIL single_res got=%0d exp=6", got_res); end
        n_tests++; if (got_cyc !== 7) begin n_fail++; $display("FAIL single_latency got=%0d exp=7", got_cyc); end
        n_tests++; if (got_st !== 6) begin n_fail++; $display("FAIL single_start_cycles got=%0d exp=6", got_st); end
        n_tests++; if (busy !== 1'b1 || mul_start !== 1'b0) begin n_fail++; $display("FAIL single_done_ctrl busy=%b start=%b exp=1/0", busy, mul_start); end
        @(negedge clk);
        n_tests++; if (done !== 4'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_after done=%b busy=%b exp=0000/0", done, busy); end
        n_tests++; if (res_out !== 8'd6) begin n_fail++; $display("FAIL single_hold got=%0d exp=6", res_out); end
    endtask

    task automatic test_round_robin();
        int exp_res[4];
        exp_res = '{6, 225, 0, 56};
        do_reset();
        a_in = {4'd7, 4'd0, 4'd15, 4'd2};
        b_in = {4'd8, 4'd9, 4'd15, 4'd3};
        req  = 4'b1111;
        for (int t = 0; t < 4; t++) begin
            wait_done(got_id, got_res, got_cyc, got_st);
            n_tests++; if (got_id !== t) begin n_fail++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", t, got_id, t); end
            n_tests++; if (int'(got_res) !== exp_res[t]) begin n_fail++; $display("FAIL rr_res[%0d] got=%0d exp=%0d", t, got_res, exp_res[t]); end
            n_tests++; if (got_cyc !== ((t == 0) ? 7 : 8)) begin n_fail++; $display("FAIL rr_spacing[%0d] got=%0d exp=%0d", t, got_cyc, (t == 0) ? 7 : 8); end
        end
    endtask

    task automatic test_fairness();
        do_reset();
        a_in = {4'd0, 4'd4, 4'd0, 4'd3};
        b_in = {4'd0, 4'd5, 4'd0, 4'd3};
        req = 4'b0001;
        repeat (3) @(negedge clk);
        req[2] = 1'b1;
        wait_done(got_id, got_res, got_cyc, got_st);
        req[0] = 1'b1;
        n_tests++; if (got_id !== 0 || got_res !== 8'd9) begin n_fail++; $display("FAIL fair_first id=%0d res=%0d exp=0/9", got_id, got_res); end
        wait_done(got_id, got_res, got_cyc, got_st);
        n_tests++; if (got_id !== 2 || got_res !== 8'd20) begin n_fail++; $display("FAIL fair_second id=%0d res=%0d exp=2/20", got_id, got_res); end
        wait_done(got_id, got_res, got_cyc, got_st);
        n_tests++; if (got_id !== 0 || got_res !== 8'd9) begin n_fail++; $display("FAIL fair_third id=%0d res=%0d exp=0/9", got_id, got_res); end
        req = '0;
    endtask

    task automatic test_reset_mid_run();
        int pulses;
        do_reset();
        a_in = 16'h0005; b_in = 16'h0005; req = 4'b0001;
        repeat (4) @(negedge clk);
        rst = 1'b1; req = '0;
        @(negedge clk);
        rst = 1'b0;
        n_tests++; if (mul_start !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl start=%b busy=%b exp=0/0", mul_start, busy); end
        n_tests++; if (res_out !== 8'd0) begin n_fail++; $display("FAIL midrst_res got=%0d exp=0", res_out); end
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (done !== 4'b0) pulses++;
        end
        n_tests++; if (pulses !== 0) begin n_fail++; $display("FAIL midrst_no_done got=%0d exp=0", pulses); end
        a_in = 16'h2222; b_in = 16'h3333; req = 4'b1111;
        wait_done(got_id, got_res, got_cyc, got_st);
        n_tests++; if (got_id !== 0) begin n_fail++; $display("FAIL midrst_ptr got=%0d exp=0", got_id); end
        req = '0;
    endtask

    task automatic test_operand_freeze();
        do_reset();
        a_in = 16'h000F; b_in = 16'h0003; req = 4'b0001;
        repeat (2) @(negedge clk);
        a_in = 16'h0001;
        @(negedge clk);
        n_tests++; if (mul_a !== 4'd15) begin n_fail++; $display("FAIL freeze_mul_a got=%0d exp=15", mul_a); end
        wait_done(got_id, got_res, got_cyc, got_st);
        n_tests++; if (got_res !== 8'd45) begin n_fail++; $display("FAIL freeze_res got=%0d exp=45", got_res); end
        req = '0;
    endtask

    task automatic test_wide();
        int cyc;
        do_reset();
        a_w = {32'h8000_0000, 96'd0}; b_w = {32'h8000_0000, 96'd0};
        req_w = 4'b1000;
        cyc = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (done_w != 4'b0) begin cyc = i; break; end
        end
        n_tests++; if (done_w !== 4'b1000) begin n_fail++; $display("FAIL wide_done got=%b exp=1000", done_w); end
        n_tests++; if (res_w !== 64'h4000_0000_0000_0000) begin n_fail++; $display("FAIL wide_res got=%h exp=4000000000000000", res_w); end
        n_tests++; if (id_w !== 2'd3) begin n_fail++; $display("FAIL wide_id got=%0d exp=3", id_w); end
        n_tests++; if (cyc !== 35) begin n_fail++; $display("FAIL wide_latency got=%0d exp=35", cyc); end
        req_w = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_reset_mid_run();
        test_operand_freeze();
        test_wide();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
